rgb_conv_sequencer: RTL

Sequences the shared 3-phase RGB colourspace converter (Y, then V, then U; one pixel per 3 cycles) for a frame of pixels.
- Accepts 8-bit Y/U/V triples from the upsampler through a valid/ready handshake.
- Holds each triple stable at the converter for its full 3-cycle phase window and drives the converter enable so no phase is aborted.
- Captures the converter's clipped R/G/B and buffers them in a small output FIFO toward the SRAM writer.
- Reports frame start, busy and done.

---
 rtl/rgb_conv_sequencer_pkg.sv | 41 ++++
 rtl/rgb_conv_sequencer_if.sv | 32 +++
 rtl/rgb_conv_sequencer_out_fifo.sv | 69 ++++++
 rtl/rgb_conv_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rgb_conv_sequencer_pkg.sv
// Shared types for the RGB converter sequencer: FSM states, converter phase
// select encodings and the packed pixel formats moved through the pipeline.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Values match the converter's select input.
    typedef enum logic [1:0] {
        PH_Y = 2'd0,
        PH_V = 2'd1,
        PH_U = 2'd2
    } phase_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_Y:    nxt = PH_V;
            PH_V:    nxt = PH_U;
            default: nxt = PH_Y;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_conv_sequencer_if.sv
// Bundles the upsampler input stream, converter drive/results, SRAM-writer
// output stream and frame status of the sequencer.
interface rgb_conv_sequencer_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_Y;
    logic [7:0]  in_U;
    logic [7:0]  in_V;
    logic        conv_enable;
    logic [31:0] conv_Y;
    logic [31:0] conv_U;
    logic [31:0] conv_V;
    logic [7:0]  conv_R;
    logic [7:0]  conv_G;
    logic [7:0]  conv_B;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_RGB;
    logic        busy;
    logic        done;

    modport slave (
        input  start, in_valid, in_Y, in_U, in_V, conv_R, conv_G, conv_B, out_ready,
        output in_ready, conv_enable, conv_Y, conv_U, conv_V, out_valid, out_RGB, busy, done
    );

    modport master (
        output start, in_valid, in_Y, in_U, in_V, conv_R, conv_G, conv_B, out_ready,
        input  in_ready, conv_enable, conv_Y, conv_U, conv_V, out_valid, out_RGB, busy, done
    );
endinterface

// File: rtl/rgb_conv_sequencer_out_fifo.sv
// Generic synchronous FIFO of pixels with a registered head and occupancy count.
// Latency: push visible at the head one cycle later. Backpressure: push on full is
// dropped unless a pop happens the same cycle; pop on empty is ignored.
module rgb_out_fifo
    import rgb_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  pixel_t           push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output pixel_t           pop_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    pixel_t             mem_q [DEPTH];
    pixel_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_rdy && (count_q != '0);
        do_push  = push_vld && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_vld = (count_q != '0);
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

endmodule

// File: rtl/rgb_conv_sequencer.sv
// Feeds Y/U/V triples through the shared 3-phase RGB converter and queues the results.
// Latency: handshake at T, converter phase 0 at T+1, out_valid at T+5 on an empty FIFO.
// Backpressure: in_ready is credit-gated on FIFO space so a converter result is never dropped.
module rgb_conv_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PIXELS_PER_FRAME = 76800,
    parameter int CNT_W            = 17,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                  CLOCK_50_I,
    input  logic                  reset,
    rgb_conv_sequencer_if.slave   bus
);
    localparam int              FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] PPF   = CNT_W'(PIXELS_PER_FRAME);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    yuv_t               hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic               cap_pending_q, cap_pending_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic               conv_enable;
    logic               in_ready;
    logic               in_hs, out_hs;
    logic [1:0]         inflight;
    logic               credit_ok;
    logic               fifo_vld;
    pixel_t             fifo_dat;
    pixel_t             push_dat;
    logic [FCNT_W-1:0]  fifo_count;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        cap_pending_d = 1'b0;
        acc_cnt_d     = acc_cnt_q;
        out_cnt_d     = out_cnt_q;

        // Enable stays high through phases 1 and 2 so a pixel is never cut short.
        conv_enable = hold_valid_q || (phase_q != PH_Y);
        inflight    = {1'b0, hold_valid_q} + {1'b0, cap_pending_q};
        credit_ok   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
        in_ready    = (state_q == RUN) && (acc_cnt_q < PPF)
                      && (!hold_valid_q || (phase_q == PH_U)) && credit_ok;
        in_hs       = bus.in_valid && in_ready;
        out_hs      = fifo_vld && bus.out_ready;

        if (conv_enable) begin
            phase_d = next_phase(phase_q);
        end
        // Results are complete after the U phase; capture them one cycle later.
        if (phase_q == PH_U) begin
            hold_valid_d  = 1'b0;
            cap_pending_d = 1'b1;
        end
        if (in_hs) begin
            hold_d       = '{y: bus.in_Y, u: bus.in_U, v: bus.in_V};
            hold_valid_d = 1'b1;
            if (acc_cnt_q < PPF) begin
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
        end
        if (out_hs && (out_cnt_q < PPF)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if ((acc_cnt_q == PPF) && !hold_valid_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!cap_pending_q && (fifo_count == '0) && (out_cnt_q == PPF)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= PH_Y;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            cap_pending_q <= 1'b0;
            acc_cnt_q     <= '0;
            out_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            cap_pending_q <= cap_pending_d;
            acc_cnt_q     <= acc_cnt_d;
            out_cnt_q     <= out_cnt_d;
        end
    end

    assign push_dat = '{r: bus.conv_R, g: bus.conv_G, b: bus.conv_B};

    rgb_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_out_fifo (
        .clk      (CLOCK_50_I),
        .rst      (reset),
        .push_vld (cap_pending_q),
        .push_dat (push_dat),
        .pop_rdy  (bus.out_ready),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    assign bus.in_ready    = in_ready;
    assign bus.conv_enable = conv_enable;
    assign bus.conv_Y      = {24'd0, hold_q.y};
    assign bus.conv_U      = {24'd0, hold_q.u};
    assign bus.conv_V      = {24'd0, hold_q.v};
    assign bus.out_valid   = fifo_vld;
    assign bus.out_RGB     = fifo_dat;
    assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);

endmodule
